led_bank_sequencer: RTL and testbench

Time-shares the eight-LED bank of the iCE40 demo boards between several pattern sources. It sits between the PLL output (`sysclk`) and the LED pins. Requesters are granted round-robin for a fixed hold period measured in prescaled ticks, with an all-off gap between owners. Optional PWM dimming scales the displayed pattern.

---
 rtl/led_bank_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 35 +++
 rtl/led_bank_sequencer.sv | 162 ++++++++++++++++
 tb/tb_led_bank_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_bank_pkg                                                             |
// | Shared state encoding, LED bank width and pattern-slice helper.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package led_bank_pkg;

  localparam int LED_COUNT = 8;
  localparam int MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Extracts source idx's 8-bit pattern from a bus padded to MAX_REQ sources.
  function automatic logic [LED_COUNT-1:0] pattern_slice(
    input logic [LED_COUNT*MAX_REQ-1:0] bus,
    input logic [2:0]                   idx
  );
    return bus[{idx, 3'b000} +: LED_COUNT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tick_prescaler                                                           |
// | Free-running divider producing a one-cycle tick every CLK_FREQ/TICK_HZ.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tick_prescaler #(
  parameter int CLK_FREQ = 204_000_000,
  parameter int TICK_HZ  = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/led_bank_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_bank_sequencer                                                       |
// | Round-robin time-sharing of the 8-LED bank with an all-off gap between   |
// | owners. Define LED_BANK_SEQUENCER_PWM_EN to add brightness PWM dimming.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module led_bank_sequencer
  import led_bank_pkg::*;
#(
  parameter int CLK_FREQ   = 204_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int NUM_REQ    = 4,
  parameter int HOLD_TICKS = 500
) (
  input  logic                           sysclk,
  input  logic                           reset,
  input  logic                           locked,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [LED_COUNT*NUM_REQ-1:0]   pattern,
  input  logic [7:0]                     brightness,
  output logic [NUM_REQ-1:0]             grant,
  output logic [LED_COUNT-1:0]           leds,
  output logic                           busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                    state, state_next;
  logic [PTR_W-1:0]          rr_ptr, rr_next;
  logic [15:0]               hold, hold_next;
  logic [LED_COUNT-1:0]      latched, latched_next;
  logic [NUM_REQ-1:0]        grant_next;
  logic [LED_COUNT-1:0]      leds_next;
  logic                      busy_next;
  logic                      tick;
  logic                      owner_req;
  logic [PTR_W-1:0]          win, win_hi, win_lo;
  logic                      found_hi;
  logic [LED_COUNT*MAX_REQ-1:0] pattern_ext;
  logic [LED_COUNT-1:0]      pwm_mask;

  tick_prescaler #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ)
  ) u_tick (
    .clk  (sysclk),
    .rst  (reset),
    .tick (tick)
  );

`ifdef LED_BANK_SEQUENCER_PWM_EN
  logic [7:0] phase;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else begin
      phase <= phase + 8'd1;
    end
  end

  assign pwm_mask = (phase < brightness) ? '1 : '0;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_mask          = '1;
`endif

  always_comb begin
    pattern_ext = '0;
    pattern_ext[LED_COUNT*NUM_REQ-1:0] = pattern;
  end

  // Lowest asserted index at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        win_lo = PTR_W'(j);
        if (PTR_W'(j) >= rr_ptr) begin
          win_hi   = PTR_W'(j);
          found_hi = 1'b1;
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  assign owner_req = |(req & grant);

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    latched_next = latched;
    hold_next    = hold;
    rr_next      = rr_ptr;
    case (state)
      IDLE: begin
        grant_next = '0;
        if (locked && |req) begin
          state_next   = SHOW;
          grant_next   = NUM_REQ'(1) << win;
          latched_next = pattern_slice(pattern_ext, 3'(win));
          hold_next    = 16'(HOLD_TICKS);
          rr_next      = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
        end
      end
      SHOW: begin
        if (tick) begin
          hold_next = hold - 16'd1;
        end
        if (!owner_req || (tick && hold == 16'd1)) begin
          state_next = GAP;
          grant_next = '0;
        end
      end
      GAP: begin
        grant_next = '0;
        if (tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase

    if (!locked) begin
      state_next = IDLE;
      grant_next = '0;
    end

    leds_next = (state_next == SHOW) ? (latched_next & pwm_mask) : '0;
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      hold    <= '0;
      latched <= '0;
      grant   <= '0;
      leds    <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      rr_ptr  <= rr_next;
      hold    <= hold_next;
      latched <= latched_next;
      grant   <= grant_next;
      leds    <= leds_next;
      busy    <= busy_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_bank_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_bank_sequencer                                                    |
// | Scoreboard bench: predicted output-change events vs. observed changes.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_led_bank_sequencer;

  localparam int CLK_FREQ   = 1000;
  localparam int TICK_HZ    = 100;
  localparam int NUM_REQ    = 4;
  localparam int HOLD_TICKS = 3;
  localparam int DIV        = CLK_FREQ / TICK_HZ;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        locked = 1'b0;
  logic [3:0]  req    = '0;
  logic [31:0] pattern = '0;
  logic [7:0]  brightness = 8'hFF;
  logic [3:0]  grant;
  logic [7:0]  leds;
  logic        busy;

  led_bank_sequencer #(
    .CLK_FREQ   (CLK_FREQ),
    .TICK_HZ    (TICK_HZ),
    .NUM_REQ    (NUM_REQ),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .locked     (locked),
    .req        (req),
    .pattern    (pattern),
    .brightness (brightness),
    .grant      (grant),
    .leds       (leds),
    .busy       (busy)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [7:0] leds;
  } ev_t;

  ev_t   exp_q[$];
  ev_t   obs_q[$];
  int    cyc;
  int    n_cmp = 0;
  int    n_err = 0;
  logic [11:0] prev;

  // Edge index since reset release; after edge k the prescaler holds k % DIV.
  always @(posedge sysclk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge sysclk) begin
    #1;
    if (reset) begin
      prev = '0;
      obs_q.delete();
    end else if ({grant, leds} !== prev) begin
      obs_q.push_back(mk(cyc, grant, leds));
      prev = {grant, leds};
    end
  end

  function automatic ev_t mk(input int c, input logic [3:0] g, input logic [7:0] l);
    ev_t e;
    e.cyc = c; e.grant = g; e.leds = l;
    return e;
  endfunction

  function automatic int next_tick(input int e);
    int t;
    t = e + 1;
    while (t % DIV != 0) t++;
    return t;
  endfunction

  function automatic int hold_end(input int s);
    int t;
    t = s;
    for (int k = 0; k < HOLD_TICKS; k++) t = next_tick(t);
    return t;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic pop_pair(output ev_t e, output ev_t o, output bit have);
    e    = exp_q.pop_front();
    have = (obs_q.size() != 0);
    if (have) o = obs_q.pop_front();
    else      o = mk(-1, 4'hx, 8'hx);
  endtask

  task automatic do_reset();
    @(posedge sysclk);
    #3;
    reset  = 1'b1;
    req    = '0;
    locked = 1'b1;
    @(posedge sysclk);
    @(posedge sysclk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (grant !== 4'b0 || leds !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got grant=%b leds=%h busy=%b, expected 0000/00/0", grant, leds, busy);
    end
    pattern = 32'h4433_2211;
    req     = 4'b0011;
    wait_cyc(2);
    n_cmp++;
    if (grant !== 4'b0001 || leds !== 8'h11) begin
      n_err++;
      $display("FAIL reset_first_grant got grant=%b leds=%h, expected 0001/11", grant, leds);
    end
    req = 4'b0010;
    wait_cyc(13);
    n_cmp++;
    if (grant !== 4'b0010 || leds !== 8'h22) begin
      n_err++;
      $display("FAIL reset_second_grant got grant=%b leds=%h, expected 0010/22", grant, leds);
    end
    req = 4'b0011;
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (grant !== 4'b0 || leds !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async got grant=%b leds=%h busy=%b, expected 0000/00/0", grant, leds, busy);
    end
    @(negedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    @(posedge sysclk);
    #1;
    n_cmp++;
    if (grant !== 4'b0001 || leds !== 8'h11) begin
      n_err++;
      $display("FAIL reset_regrant got grant=%b leds=%h, expected 0001/11", grant, leds);
    end
  endtask

  task automatic test_single();
    int  s, g, s2;
    ev_t e, o;
    bit  h;
    do_reset();
    pattern = 32'h0000_00A5;
    req     = 4'b0001;
    s  = cyc + 1;
    g  = hold_end(s);
    s2 = g + DIV + 1;
    exp_q.push_back(mk(s, 4'b0001, 8'hA5));
    exp_q.push_back(mk(g, 4'b0000, 8'h00));
    exp_q.push_back(mk(s2, 4'b0001, 8'hA5));
    wait_cyc(g + 3);
    n_cmp++;
    if (busy !== 1'b1 || grant !== 4'b0) begin
      n_err++;
      $display("FAIL single_gap_busy got busy=%b grant=%b, expected 1/0000", busy, grant);
    end
    wait_cyc(s2 + 1);
    #2;
    while (exp_q.size() != 0) begin
      pop_pair(e, o, h);
      n_cmp++;
      if (!h || o.cyc != e.cyc || o.grant !== e.grant || o.leds !== e.leds) begin
        n_err++;
        $display("FAIL single_event got cyc=%0d grant=%b leds=%h, expected cyc=%0d grant=%b leds=%h",
                 o.cyc, o.grant, o.leds, e.cyc, e.grant, e.leds);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL single_extra got %0d unexpected changes, expected 0", obs_q.size());
    end
  endtask

  task automatic test_round_robin();
    int          s, g;
    logic [31:0] pv;
    ev_t         e, o;
    bit          h;
    do_reset();
    pv      = 32'h4433_2211;
    pattern = pv;
    req     = 4'b1111;
    s       = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(mk(s, 4'(1 << (k % 4)), pv[8*(k%4) +: 8]));
      g = hold_end(s);
      if (k < 4) exp_q.push_back(mk(g, 4'b0000, 8'h00));
      if (k < 4) s = g + DIV + 1;
    end
    wait_cyc(s + 1);
    #2;
    while (exp_q.size() != 0) begin
      pop_pair(e, o, h);
      n_cmp++;
      if (!h || o.cyc != e.cyc || o.grant !== e.grant || o.leds !== e.leds) begin
        n_err++;
        $display("FAIL rr_event got cyc=%0d grant=%b leds=%h, expected cyc=%0d grant=%b leds=%h",
                 o.cyc, o.grant, o.leds, e.cyc, e.grant, e.leds);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL rr_extra got %0d unexpected changes, expected 0", obs_q.size());
    end
  endtask

  task automatic test_early_release();
    int  d, x;
    ev_t e, o;
    bit  h;
    do_reset();
    pattern = 32'h4433_2211;
    req     = 4'b1100;
    exp_q.push_back(mk(cyc + 1, 4'b0100, 8'h33));
    d = cyc + 5;
    wait_cyc(d);
    req = 4'b1000;
    exp_q.push_back(mk(d + 1, 4'b0000, 8'h00));
    x = next_tick(d + 1);
    exp_q.push_back(mk(x + 1, 4'b1000, 8'h44));
    wait_cyc(x + 2);
    #2;
    while (exp_q.size() != 0) begin
      pop_pair(e, o, h);
      n_cmp++;
      if (!h || o.cyc != e.cyc || o.grant !== e.grant || o.leds !== e.leds) begin
        n_err++;
        $display("FAIL early_event got cyc=%0d grant=%b leds=%h, expected cyc=%0d grant=%b leds=%h",
                 o.cyc, o.grant, o.leds, e.cyc, e.grant, e.leds);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL early_extra got %0d unexpected changes, expected 0", obs_q.size());
    end
  endtask

  task automatic test_pattern_latch();
    int  s, g;
    ev_t e, o;
    bit  h;
    do_reset();
    pattern = 32'h0000_0F00;
    req     = 4'b0010;
    s = cyc + 1;
    g = hold_end(s);
    exp_q.push_back(mk(s, 4'b0010, 8'h0F));
    exp_q.push_back(mk(g, 4'b0000, 8'h00));
    exp_q.push_back(mk(g + DIV + 1, 4'b0010, 8'hF0));
    wait_cyc(s + 2);
    pattern[15:8] = 8'hF0;
    for (int c = s + 4; c < g; c += 9) begin
      wait_cyc(c);
      n_cmp++;
      if (leds !== 8'h0F) begin
        n_err++;
        $display("FAIL latch_hold at cyc=%0d got leds=%h, expected 0f", cyc, leds);
      end
    end
    wait_cyc(g + DIV + 2);
    #2;
    while (exp_q.size() != 0) begin
      pop_pair(e, o, h);
      n_cmp++;
      if (!h || o.cyc != e.cyc || o.grant !== e.grant || o.leds !== e.leds) begin
        n_err++;
        $display("FAIL latch_event got cyc=%0d grant=%b leds=%h, expected cyc=%0d grant=%b leds=%h",
                 o.cyc, o.grant, o.leds, e.cyc, e.grant, e.leds);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL latch_extra got %0d unexpected changes, expected 0", obs_q.size());
    end
  endtask

  task automatic test_locked();
    ev_t e, o;
    bit  h;
    do_reset();
    pattern = 32'h4433_2211;
    req     = 4'b0011;
    exp_q.push_back(mk(2, 4'b0001, 8'h11));
    wait_cyc(5);
    locked = 1'b0;
    exp_q.push_back(mk(6, 4'b0000, 8'h00));
    wait_cyc(6);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL locked_busy got busy=%b, expected 0", busy);
    end
    wait_cyc(9);
    locked = 1'b1;
    exp_q.push_back(mk(10, 4'b0010, 8'h22));
    wait_cyc(11);
    #2;
    while (exp_q.size() != 0) begin
      pop_pair(e, o, h);
      n_cmp++;
      if (!h || o.cyc != e.cyc || o.grant !== e.grant || o.leds !== e.leds) begin
        n_err++;
        $display("FAIL locked_event got cyc=%0d grant=%b leds=%h, expected cyc=%0d grant=%b leds=%h",
                 o.cyc, o.grant, o.leds, e.cyc, e.grant, e.leds);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL locked_extra got %0d unexpected changes, expected 0", obs_q.size());
    end
  endtask

`ifdef LED_BANK_SEQUENCER_PWM_EN
  task automatic test_pwm();
    logic [7:0] want;
    do_reset();
    pattern    = 32'h0000_00FF;
    brightness = 8'd64;
    wait_cyc(55);
    req = 4'b0001;
    for (int k = 56; k < 78; k++) begin
      wait_cyc(k);
      want = (((k - 1) % 256) < 64) ? 8'hFF : 8'h00;
      n_cmp++;
      if (leds !== want) begin
        n_err++;
        $display("FAIL pwm_64 at cyc=%0d got leds=%h, expected %h", cyc, leds, want);
      end
    end
    brightness = 8'd0;
    wait_cyc(79);
    for (int k = 80; k < 86; k++) begin
      wait_cyc(k);
      n_cmp++;
      if (leds !== 8'h00) begin
        n_err++;
        $display("FAIL pwm_0 at cyc=%0d got leds=%h, expected 00", cyc, leds);
      end
    end
    brightness = 8'hFF;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_pattern_latch();
    test_locked();
`ifdef LED_BANK_SEQUENCER_PWM_EN
    test_pwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
